sram_ctrl: RTL

// Synchronous front end for the asynchronous sram_model (10-bit addr, 8-bit bidir data, oe_n, we_n).

---
 rtl/sram_ctrl_if.sv | 33 +++
 rtl/sram_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/sram_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_ctrl_if
// Request/response bus between core logic and the SRAM front end.
//   req_valid  master->slave  request present
//   req_ready  slave->master  controller idle, request taken on valid&ready
//   req_we     master->slave  1 = write, 0 = read
//   req_addr   master->slave  request address
//   req_wdata  master->slave  write data
//   rsp_valid  slave->master  one-cycle strobe, rsp_rdata holds new read data
//   rsp_rdata  slave->master  read data, held until the next read completes
// ---------------------------------------------------------------------------
interface sram_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
// Synchronous front end for an asynchronous SRAM (addr, bidir dq, oe_n, we_n).
// Turns single-cycle valid/ready requests into sequenced SRAM pin activity:
// write = address/data setup, we_n pulse, data hold; read = oe_n window with
// dq sampled on its last edge, followed by a one-cycle response strobe.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   bus        sram_ctrl_if.slave request/response bus
//   sram_addr  SRAM address (registered)
//   sram_dq    SRAM data, driven only in write states, otherwise released
//   sram_oe_n  SRAM output enable, active low (registered)
//   sram_we_n  SRAM write enable, active low (registered)
// ---------------------------------------------------------------------------
module sram_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int WR_CYCLES = 2,
  parameter int RD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  sram_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int MAX_CYC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_RD_WAIT,
    S_RD_DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_dq_oe;
  logic              r_we_n;
  logic              r_oe_n;

  // Every SRAM pin comes straight from a register; the request bus only
  // reaches the pins through the accept edge in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_addr      <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        // Accept: address (and write data) captured, pins change next cycle
        S_IDLE: begin
          if (bus.req_valid) begin
            r_addr  <= bus.req_addr;
            r_ready <= 1'b0;
            if (bus.req_we) begin
              r_wdata <= bus.req_wdata;
              r_dq_oe <= 1'b1;
              r_state <= S_WR_SETUP;
            end else begin
              // oe_n falls together with the new address; the SRAM is
              // asynchronous and only the sampling edge matters.
              r_oe_n  <= 1'b0;
              r_cnt   <= CNT_W'(RD_CYCLES - 1);
              r_state <= S_RD_WAIT;
            end
          end
        end
        // Write setup: address and data already stable, strobe still high
        S_WR_SETUP: begin
          r_we_n  <= 1'b0;
          r_cnt   <= CNT_W'(WR_CYCLES - 1);
          r_state <= S_WR_PULSE;
        end
        // Write pulse: we_n low for WR_CYCLES cycles
        S_WR_PULSE: begin
          if (r_cnt == '0) begin
            r_we_n  <= 1'b1;
            r_state <= S_WR_HOLD;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        // Write hold: data kept on dq one cycle past the rising we_n
        S_WR_HOLD: begin
          r_dq_oe <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        // Read window: dq sampled on the edge that closes the window
        S_RD_WAIT: begin
          if (r_cnt == '0) begin
            r_rdata     <= sram_dq;
            r_oe_n      <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RD_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        // Read done: response strobe is high in this cycle
        S_RD_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_dq_oe <= 1'b0;
          r_we_n  <= 1'b1;
          r_oe_n  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign sram_addr     = r_addr;
  assign sram_we_n     = r_we_n;
  assign sram_oe_n     = r_oe_n;
  assign sram_dq       = r_dq_oe ? r_wdata : {DATA_W{1'bz}};

endmodule
